// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/kill bundle between the pipeline and the register scoreboard.
// master: pipeline side (drives ID, WB, kill); slave: scoreboard (returns stall/issue/status).
interface reg_scoreboard_if;
    logic       id_valid;
    logic [4:0] id_ra;
    logic [4:0] id_rb;
    logic       id_ra_use;
    logic       id_rb_use;
    logic [4:0] id_rw;
    logic       id_wen;
    logic       stall;
    logic       issue;
    logic       wb_wen;
    logic [4:0] wb_rw;
    logic       kill_wen;
    logic [4:0] kill_rw;
    logic       any_pending;
    logic       err;

    modport master (
        output id_valid, id_ra, id_rb, id_ra_use, id_rb_use,
        output id_rw, id_wen, wb_wen, wb_rw, kill_wen, kill_rw,
        input  stall, issue, any_pending, err
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_ra_use, id_rb_use,
        input  id_rw, id_wen, wb_wen, wb_rw, kill_wen, kill_rw,
        output stall, issue, any_pending, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters; stalls ID while a source awaits WB.
// Ports: clk, rst (async high), sb (slave: ID/WB/kill in, stall/issue/any_pending/err out).
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    reg_scoreboard_if.slave   sb
);
    localparam int W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 is held at zero so r0 never reads as pending.
    logic [31:0][CNT_W-1:0] cnt_q;
    logic [31:0][CNT_W-1:0] cnt_d;
    logic [31:0][1:0]       ret;
    logic                   any_pending_q;
    logic                   any_pending_d;
    logic                   err_q;
    logic                   err_d;
    logic                   haz_a;
    logic                   haz_b;
    logic                   ovf;
    logic                   stall;
    logic                   issue;
    logic                   inc;
    logic [W-1:0]           sum;
    logic [W-1:0]           dec;

    // Same-cycle retires (WB and kill) per register, 0..2.
    always_comb begin
        ret = '0;
        for (int r = 1; r < 32; r++) begin
            ret[r] = 2'(sb.wb_wen && sb.wb_rw == 5'(r))
                   + 2'(sb.kill_wen && sb.kill_rw == 5'(r));
        end
    end

    // A source is clear once every pending write retires this cycle,
    // because the register file writes on negedge.
    always_comb begin
        haz_a = sb.id_ra_use && sb.id_ra != 5'd0
             && (W'(cnt_q[sb.id_ra]) > W'(ret[sb.id_ra]));
        haz_b = sb.id_rb_use && sb.id_rb != 5'd0
             && (W'(cnt_q[sb.id_rb]) > W'(ret[sb.id_rb]));
        ovf   = sb.id_wen && sb.id_rw != 5'd0
             && cnt_q[sb.id_rw] == CNT_MAX
             && ret[sb.id_rw] == 2'd0;
        stall = sb.id_valid && (haz_a || haz_b || ovf);
        issue = sb.id_valid && !stall;
    end

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.any_pending = any_pending_q;
    assign sb.err         = err_q;

    // Net update computed in a wider domain so nothing wraps transiently.
    always_comb begin
        cnt_d         = '0;
        err_d         = err_q;
        any_pending_d = 1'b0;
        inc           = 1'b0;
        sum           = '0;
        dec           = '0;
        for (int r = 1; r < 32; r++) begin
            inc = issue && sb.id_wen && sb.id_rw == 5'(r);
            sum = W'(cnt_q[r]) + W'(inc);
            dec = W'(ret[r]);
            if (W'(cnt_q[r]) < dec) begin
                err_d = 1'b1;
            end
            if (sum < dec) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = CNT_W'(sum - dec);
            end
            if (cnt_d[r] != '0) begin
                any_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            any_pending_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            any_pending_q <= any_pending_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes between issue (ID) and the register-file write port (WB) in the 5-stage pipeline.
- It is the consumer side of the register-file interface:
  - It decides when the ID stage may safely read busA/busB.
  - It stalls issue while a source register still awaits writeback.
- It mirrors the register-file write port (wEn/Rw) to retire pending writes.
- Squashed instructions are retired through a kill port.

Parameters:
- CNT_W, 2, width of the per-register pending counter. At most 2^CNT_W-1 writes may be outstanding per register.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  an instruction is presented for issue this cycle.
- id_ra  input  5  source register A.
- id_rb  input  5  source register B.
- id_ra_use  input  1  source A is actually read.
- id_rb_use  input  1  source B is actually read.
- id_rw  input  5  destination register.
- id_wen  input  1  instruction writes id_rw.
- stall  output  1  issue blocked this cycle (combinational).
- issue  output  1  id_valid && !stall (combinational); pending state updated on this.
- wb_wen  input  1  register-file write enable, same signal as the RegFile wEn.
- wb_rw  input  5  register-file write address, same signal as the RegFile Rw.
- kill_wen  input  1  a squashed instruction with a pending write is retired without writeback.
- kill_rw  input  5  destination register of the squashed instruction.
- any_pending  output  1  registered; 1 if any counter is nonzero.
- err  output  1  registered, sticky; retire of a register whose count is 0.

Behaviour:
- State: cnt[1..31], each CNT_W bits. Register 0 has no counter; reads and writes of r0 are ignored.
- Reset (async, rst=1): all cnt=0, any_pending=0, err=0. Reset mid-operation discards all pending state immediately.
- Effective pending count, pend(r):
  - pend(r) = cnt[r] - (wb_wen && wb_rw==r && r!=0) - (kill_wen && kill_rw==r && r!=0).
  - Writeback is visible the same cycle: the register file writes on negedge, so ID reads the new value in the second half-cycle.
  - Floor of pend(r) at 0.
- stall = id_valid && (hazA || hazB || ovf):
  - hazA = id_ra_use && id_ra!=0 && pend(id_ra)>0.
  - hazB = id_rb_use && id_rb!=0 && pend(id_rb)>0.
  - ovf = id_wen && id_rw!=0 && cnt[id_rw]==2^CNT_W-1 && no retire of id_rw this cycle.
- Posedge update per register r!=0:
  - cnt[r] += (issue && id_wen && id_rw==r).
  - cnt[r] -= (wb_wen && wb_rw==r).
  - cnt[r] -= (kill_wen && kill_rw==r).
  - All terms are applied simultaneously.
- Simultaneous events:
  - Issue and retire of the same register in one cycle: net change only; never transiently wraps.
  - WB and kill of the same register: decrement by 2 if cnt>=2.
- Underflow: a retire while cnt[r]==0 (after accounting for the other same-cycle retire) leaves cnt at 0 and sets err=1. err clears only on rst.
- No wrap-around: a counter never exceeds 2^CNT_W-1, because ovf stalls issue. It never goes below 0.
- Retire to r0 (wb_rw==0 or kill_rw==0) is a no-op and never sets err.
- id_rw==0 with id_wen=1: issue proceeds, no counter change.
- any_pending is registered from the next-state counters: it is 1 in the cycle after any counter becomes nonzero.
- stall and issue are purely combinational from inputs and cnt. There is no cycle of latency between a WB retire and the release of a stall.

Test Plan:
- Reset then id_valid=1, ra=5, rb=6, uses=1 -> stall=0, issue=1, any_pending=0, err=0.
- Issue rw=3 wen=1; next cycle issue ra=3 -> stall=1. Assert wb_wen=1, wb_rw=3 in that cycle -> stall=0 the same cycle; cnt[3]=0 afterwards.
- Issue rw=7 three times with no retire (CNT_W=2) -> fourth issue with rw=7 gives stall=1 (ovf). Same cycle with wb_rw=7 wb_wen=1 -> stall=0 and cnt[7] stays 3.
- cnt[9]=2: same cycle wb_rw=9 and kill_rw=9 -> cnt[9]=0 and any_pending=0 next cycle. A further kill_rw=9 -> err=1 and stays 1.
- Issue rw=0 wen=1, then read ra=0 -> no stall, any_pending=0. wb_rw=0 wb_wen=1 -> err stays 0.
- cnt[4]=1 and any_pending=1; assert rst mid-cycle (async) -> cnt cleared and any_pending=0 immediately. After rst deasserts, read ra=4 -> stall=0.
